uart_wb_master: RTL and testbench

- Command-driven bus master that sits directly upstream of the UART's register interface and turns byte-level commands into complete UART bus transactions.
- Commands are TX byte write, RX byte read and frequency-divider write.
- The UART side uses a four-phase strobe handshake: wb_stb qualifies, wb_clk strobes, wb_ack answers.
- Each command returns exactly one response (data or error) on a valid-only response port.

---
 rtl/uart_wb_master.sv | 180 ++++++++++++++++++
 tb/tb_uart_wb_master.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_master.sv
// Command-driven master for the UART register bus: accepts one byte-level command,
// runs one stb/clk/ack handshake and returns exactly one response per command.
module uart_wb_master #(
    parameter int TIMEOUT = 1024,
    parameter int GAP     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [1:0] i_cmd_op,
    input  logic [7:0] i_cmd_data,
    output logic       o_rsp_valid,
    output logic [7:0] o_rsp_data,
    output logic       o_rsp_err,
    output logic [1:0] o_wb_addr,
    output logic [7:0] o_wb_data_out,
    input  logic [7:0] i_wb_data_in,
    output logic       o_wb_we,
    output logic       o_wb_stb,
    output logic       o_wb_clk,
    input  logic       i_wb_ack
);

    localparam int TMO_W = $clog2(TIMEOUT) + 1;
    localparam int GAP_W = $clog2(GAP + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_RELEASE,
        S_DONE,
        S_ABORT
    } state_t;

    state_t           r_state;
    logic [TMO_W-1:0] r_tmo;
    logic [GAP_W-1:0] r_gap;
    logic [7:0]       r_capture;
    logic             r_cmd_ready;
    logic             r_rsp_valid;
    logic [7:0]       r_rsp_data;
    logic             r_rsp_err;
    logic [1:0]       r_wb_addr;
    logic [7:0]       r_wb_data_out;
    logic             r_wb_we;
    logic             r_wb_stb;
    logic             r_wb_clk;

    state_t           w_state_next;
    logic [TMO_W-1:0] w_tmo_next;
    logic [GAP_W-1:0] w_gap_next;
    logic [7:0]       w_capture_next;
    logic             w_cmd_ready_next;
    logic             w_rsp_valid_next;
    logic [7:0]       w_rsp_data_next;
    logic             w_rsp_err_next;
    logic [1:0]       w_addr_next;
    logic [7:0]       w_wdata_next;
    logic             w_we_next;
    logic             w_stb_next;
    logic             w_clk_next;

    // Outputs are derived from the next state so every port comes straight from a flop.
    always_comb begin
        w_state_next   = r_state;
        w_tmo_next     = '0;
        w_gap_next     = r_gap;
        w_capture_next = r_capture;
        w_addr_next    = r_wb_addr;
        w_wdata_next   = r_wb_data_out;
        w_we_next      = r_wb_we;

        case (r_state)
            S_IDLE: begin
                if (r_gap != '0) begin
                    w_gap_next = r_gap - 1'b1;
                end
                if (i_cmd_valid && r_cmd_ready) begin
                    if (i_cmd_op == 2'b11) begin
                        w_state_next = S_ABORT;
                    end else begin
                        w_state_next   = S_SETUP;
                        w_addr_next    = i_cmd_op;
                        w_wdata_next   = i_cmd_data;
                        w_we_next      = (i_cmd_op == 2'b01);
                        w_capture_next = '0;
                    end
                end
            end
            S_SETUP: begin
                w_state_next = S_STROBE;
            end
            S_STROBE: begin
                if (i_wb_ack) begin
                    w_capture_next = i_wb_data_in;
                    w_state_next   = S_RELEASE;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_next = S_ABORT;
                end else begin
                    w_tmo_next = r_tmo + 1'b1;
                end
            end
            // Keep re-capturing while ack lingers so the last acknowledged byte wins.
            S_RELEASE: begin
                if (!i_wb_ack) begin
                    w_state_next = S_DONE;
                end else begin
                    w_capture_next = i_wb_data_in;
                    if (r_tmo == TMO_LAST) begin
                        w_state_next = S_ABORT;
                    end else begin
                        w_tmo_next = r_tmo + 1'b1;
                    end
                end
            end
            S_DONE, S_ABORT: begin
                w_gap_next   = GAP_LOAD;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_cmd_ready_next = (w_state_next == S_IDLE) && (w_gap_next == '0);
        w_rsp_valid_next = (w_state_next == S_DONE) || (w_state_next == S_ABORT);
        w_rsp_err_next   = (w_state_next == S_ABORT);
        w_rsp_data_next  = ((w_state_next == S_DONE) && r_wb_we) ? w_capture_next : 8'h00;
        w_stb_next       = (w_state_next == S_SETUP) || (w_state_next == S_STROBE)
                        || (w_state_next == S_RELEASE);
        w_clk_next       = (w_state_next == S_STROBE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_tmo         <= '0;
            r_gap         <= '0;
            r_capture     <= '0;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_err     <= 1'b0;
            r_wb_addr     <= '0;
            r_wb_data_out <= '0;
            r_wb_we       <= 1'b1;
            r_wb_stb      <= 1'b0;
            r_wb_clk      <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_tmo         <= w_tmo_next;
            r_gap         <= w_gap_next;
            r_capture     <= w_capture_next;
            r_cmd_ready   <= w_cmd_ready_next;
            r_rsp_valid   <= w_rsp_valid_next;
            r_rsp_data    <= w_rsp_data_next;
            r_rsp_err     <= w_rsp_err_next;
            r_wb_addr     <= w_addr_next;
            r_wb_data_out <= w_wdata_next;
            r_wb_we       <= w_we_next;
            r_wb_stb      <= w_stb_next;
            r_wb_clk      <= w_clk_next;
        end
    end

    assign o_cmd_ready   = r_cmd_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_data    = r_rsp_data;
    assign o_rsp_err     = r_rsp_err;
    assign o_wb_addr     = r_wb_addr;
    assign o_wb_data_out = r_wb_data_out;
    assign o_wb_we       = r_wb_we;
    assign o_wb_stb      = r_wb_stb;
    assign o_wb_clk      = r_wb_clk;

endmodule

// File: tb/tb_uart_wb_master.sv
// Bench for uart_wb_master: fixed vectors, random transactions against a
// transaction-level model with a behavioural UART slave, plus corner sequences.
module tb_uart_wb_master;

    localparam int TIMEOUT = 8;
    localparam int GAP     = 2;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       cmdValid  = 1'b0;
    logic       cmdReady;
    logic [1:0] cmdOp     = 2'b00;
    logic [7:0] cmdData   = 8'h00;
    logic       rspValid;
    logic [7:0] rspData;
    logic       rspErr;
    logic [1:0] wbAddr;
    logic [7:0] wbDataOut;
    logic [7:0] wbDataIn  = 8'h00;
    logic       wbWe;
    logic       wbStb;
    logic       wbClk;
    logic       wbAck     = 1'b0;

    // Slave behaviour: mode 0 normal, 1 never acks, 2 ack stuck high once raised.
    int         slvMode     = 0;
    int         slvHold     = 0;
    int         holdLeft    = 0;
    bit         slvRandom   = 1'b0;
    logic [7:0] slvData     = 8'h00;
    logic [7:0] lastAckData = 8'h00;

    int testsRun    = 0;
    int testsFailed = 0;
    int cycle       = 0;

    int resGot, resLat, resData, resErr, resBusErr, resStb, resStrobe, resRelease, resExtra, resGap;

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        int         hold;
        logic [7:0] slaveData;
        int         expLat;
        int         expErr;
        int         expData;
        int         expStb;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    uart_wb_master #(.TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_cmd_valid  (cmdValid),
        .o_cmd_ready  (cmdReady),
        .i_cmd_op     (cmdOp),
        .i_cmd_data   (cmdData),
        .o_rsp_valid  (rspValid),
        .o_rsp_data   (rspData),
        .o_rsp_err    (rspErr),
        .o_wb_addr    (wbAddr),
        .o_wb_data_out(wbDataOut),
        .i_wb_data_in (wbDataIn),
        .o_wb_we      (wbWe),
        .o_wb_stb     (wbStb),
        .o_wb_clk     (wbClk),
        .i_wb_ack     (wbAck)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] packOutputs();
        return {cmdReady, rspValid, rspErr, rspData, wbStb, wbClk, wbWe, wbAddr, wbDataOut};
    endfunction

    task automatic slaveStep();
        if (wbStb !== 1'b1) begin
            wbAck = 1'b0;
        end else if (slvMode == 1) begin
            wbAck = 1'b0;
        end else if (wbClk === 1'b1) begin
            wbAck    = 1'b1;
            holdLeft = slvHold;
        end else if (wbAck) begin
            if (slvMode == 2) begin
                wbAck = 1'b1;
            end else if (holdLeft > 0) begin
                holdLeft--;
                wbAck = 1'b1;
            end else begin
                wbAck = 1'b0;
            end
        end
        if (wbAck) begin
            wbDataIn    = slvRandom ? 8'($urandom) : slvData;
            lastAckData = wbDataIn;
        end else begin
            wbDataIn = 8'($urandom);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cycle++;
        slaveStep();
    endtask

    task automatic waitReady(input string name);
        int waited = 0;
        while (cmdReady !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        checkOutput(name, int'(cmdReady === 1'b1), 1);
    endtask

    // Issues one command, follows it to its response, then measures the ready gap.
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] data);
        resGot = 0; resLat = 0; resData = 0; resErr = 0; resBusErr = 0;
        resStb = 0; resStrobe = 0; resRelease = 0; resExtra = 0; resGap = 0;
        waitReady("cmd_ready_wait");
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdData  = data;
        tick();
        cmdValid = 1'b0;
        cmdOp    = 2'($urandom);
        cmdData  = 8'($urandom);
        resLat   = 1;
        while (resLat <= 40) begin
            if (wbStb) begin
                resStb++;
                if (wbClk) resStrobe++;
                else if (resStb > 1) resRelease++;
                if (wbAddr !== op || wbWe !== (op == 2'b01) || (op != 2'b01 && wbDataOut !== data))
                    resBusErr++;
                if (resLat == 1 && wbClk) resBusErr++;
            end
            if (rspValid) begin
                resGot  = 1;
                resData = int'(rspData);
                resErr  = int'(rspErr);
                if (wbStb || wbClk) resBusErr++;
                break;
            end
            tick();
            resLat++;
        end
        while (resGot == 1 && resGap < 50) begin
            tick();
            if (rspValid) resExtra++;
            if (cmdReady) break;
            resGap++;
        end
    endtask

    function automatic int modelLatency(input logic [1:0] op, input int hold);
        return (op == 2'b11) ? 1 : 4 + hold;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [23:0] expReset;
        int          rspCount;
        bit          prevStb;
        int          rises[$];
        logic [1:0]  rOp;
        logic [7:0]  rData;
        int          rHold;
        int          expData;

        vecs[0] = '{2'b00, 8'h41, 0, 8'h33, 4, 0, 8'h00, 3};
        vecs[1] = '{2'b01, 8'h00, 0, 8'h5A, 4, 0, 8'h5A, 3};
        vecs[2] = '{2'b10, 8'h9C, 0, 8'h77, 4, 0, 8'h00, 3};
        vecs[3] = '{2'b11, 8'hFF, 0, 8'h12, 1, 1, 8'h00, 0};
        vecs[4] = '{2'b01, 8'h00, 2, 8'hC3, 6, 0, 8'hC3, 5};
        vecs[5] = '{2'b00, 8'h7E, 1, 8'h44, 5, 0, 8'h00, 4};
        expReset = {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00};

        reset = 1'b1;
        repeat (3) tick();
        checkOutput("reset_values", int'(packOutputs()), int'(expReset));
        reset = 1'b0;
        tick();
        checkOutput("ready_after_reset", int'(cmdReady), 1);

        for (int i = 0; i < 6; i++) begin
            slvMode   = 0;
            slvRandom = 1'b0;
            slvHold   = vecs[i].hold;
            slvData   = vecs[i].slaveData;
            applyStimulus(vecs[i].op, vecs[i].data);
            checkOutput($sformatf("vec%0d_got", i), resGot, 1);
            checkOutput($sformatf("vec%0d_lat", i), resLat, vecs[i].expLat);
            checkOutput($sformatf("vec%0d_err", i), resErr, vecs[i].expErr);
            checkOutput($sformatf("vec%0d_data", i), resData, vecs[i].expData);
            checkOutput($sformatf("vec%0d_stb", i), resStb, vecs[i].expStb);
            checkOutput($sformatf("vec%0d_bus", i), resBusErr, 0);
            checkOutput($sformatf("vec%0d_extra", i), resExtra, 0);
            checkOutput($sformatf("vec%0d_gap", i), resGap, GAP);
        end

        slvRandom = 1'b1;
        for (int i = 0; i < 30; i++) begin
            rOp     = 2'($urandom_range(0, 3));
            rData   = 8'($urandom);
            rHold   = $urandom_range(0, 3);
            slvMode = 0;
            slvHold = rHold;
            applyStimulus(rOp, rData);
            expData = (rOp == 2'b01) ? int'(lastAckData) : 0;
            checkOutput($sformatf("rnd%0d_lat", i), resLat, modelLatency(rOp, rHold));
            checkOutput($sformatf("rnd%0d_err", i), resErr, int'(rOp == 2'b11));
            checkOutput($sformatf("rnd%0d_data", i), resData, expData);
            checkOutput($sformatf("rnd%0d_stb", i), resStb, (rOp == 2'b11) ? 0 : 3 + rHold);
            checkOutput($sformatf("rnd%0d_bus", i), resBusErr, 0);
            checkOutput($sformatf("rnd%0d_gap", i), resGap, GAP);
        end

        slvMode = 1;
        applyStimulus(2'b00, 8'hB7);
        checkOutput("noack_strobe_cycles", resStrobe, TIMEOUT);
        checkOutput("noack_err", resErr, 1);
        checkOutput("noack_data", resData, 0);
        checkOutput("noack_lat", resLat, TIMEOUT + 2);
        checkOutput("noack_bus", resBusErr, 0);
        checkOutput("noack_gap", resGap, GAP);

        slvMode = 2;
        applyStimulus(2'b01, 8'h00);
        checkOutput("stuck_strobe_cycles", resStrobe, 1);
        checkOutput("stuck_release_cycles", resRelease, TIMEOUT);
        checkOutput("stuck_err", resErr, 1);
        checkOutput("stuck_data", resData, 0);
        checkOutput("stuck_lat", resLat, TIMEOUT + 3);
        checkOutput("stuck_bus", resBusErr, 0);
        slvMode = 0;

        slvHold = 0;
        waitReady("b2b_ready");
        cmdValid = 1'b1;
        cmdOp    = 2'b00;
        cmdData  = 8'h5C;
        prevStb  = 1'b0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (wbStb && !prevStb) rises.push_back(cycle);
            prevStb = wbStb;
        end
        cmdValid = 1'b0;
        repeat (20) tick();
        checkOutput("b2b_transactions", int'(rises.size() >= 3), 1);
        if (rises.size() >= 3) begin
            checkOutput("b2b_period0", rises[1] - rises[0], 5 + GAP);
            checkOutput("b2b_period1", rises[2] - rises[1], 5 + GAP);
        end

        slvMode = 1;
        waitReady("rst_ready");
        cmdValid = 1'b1;
        cmdOp    = 2'b10;
        cmdData  = 8'hA5;
        tick();
        cmdValid = 1'b0;
        tick();
        checkOutput("rst_in_strobe", int'(wbClk), 1);
        reset = 1'b1;
        tick();
        checkOutput("rst_mid_values", int'(packOutputs()), int'(expReset));
        reset    = 1'b0;
        rspCount = 0;
        repeat (12) begin
            tick();
            if (rspValid) rspCount++;
        end
        checkOutput("rst_no_rsp", rspCount, 0);
        checkOutput("rst_ready_back", int'(cmdReady), 1);
        slvMode = 0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
